// File: rtl/mxu_pkg.sv
// Shared definitions for the matrix unit: default operand geometry and the
// operand-loader state encoding used by mxu_operand_loader and temporal_mxu.
package mxu_pkg;

    localparam int BIT_WIDTH_DEF = 8;
    localparam int DIM_DEF       = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } loader_state_e;

    // Plain-vector aliases of the enum so the FSM can be held in logic [1:0].
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    function automatic logic state_is_busy(input logic [1:0] st);
        return (st != ST_LOAD);
    endfunction

endpackage

// File: rtl/mxu_row_buffer.sv
// DIM x DIM operand store written one full row per cycle; the whole matrix is
// presented continuously so the array sees stable operands between loads.
module mxu_row_buffer
    import mxu_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DIM       = DIM_DEF,
    parameter int IDX_W     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   wr_en,
    input  logic [IDX_W-1:0]                       wr_idx,
    input  logic [DIM-1:0][BIT_WIDTH-1:0]          wr_row,
    output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] mat
);

    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] mat_q;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] mat_d;

    // Next-state: overwrite only the addressed row on an accepted beat.
    always_comb begin
        mat_d = mat_q;
        if (wr_en) begin
            mat_d[wr_idx] = wr_row;
        end else begin
            mat_d = mat_q;
        end
    end

    // Storage flops, cleared to zero by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_q <= {(DIM*DIM*BIT_WIDTH){1'b0}};
        end else begin
            mat_q <= mat_d;
        end
    end

    assign mat = mat_q;

endmodule

// File: rtl/mxu_operand_loader.sv
// Collects DIM row pairs of A and B over a valid/ready stream, then launches
// temporal_mxu with a one-cycle start pulse and waits for its result.
module mxu_operand_loader
    import mxu_pkg::*;
#(
    parameter int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int DIM       = DIM_DEF
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DIM-1:0][BIT_WIDTH-1:0]          in_row_a,
    input  logic [DIM-1:0][BIT_WIDTH-1:0]          in_row_b,
    output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] A,
    output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] B,
    output logic                                   start,
    input  logic                                   mxu_out_valid,
    output logic                                   busy
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] row_cnt_q;
    logic [CW-1:0] row_cnt_d;
    logic          start_q;
    logic          start_d;
    logic          in_ready_s;
    logic          accept_s;

    // Ready is gated by reset so upstream never sees a handshake during reset.
    assign in_ready_s = (state_q == ST_LOAD) && reset_n;
    assign accept_s   = in_valid && in_ready_s;

    // FSM and row counter next-state; start is raised on the entry into START.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        start_d   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept_s) begin
                    if (row_cnt_q == LAST_ROW) begin
                        state_d   = ST_START;
                        row_cnt_d = {CW{1'b0}};
                        start_d   = 1'b1;
                    end else begin
                        row_cnt_d = row_cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mxu_out_valid) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d   = ST_LOAD;
                row_cnt_d = {CW{1'b0}};
            end
        endcase
    end

    // Control state flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_LOAD;
            row_cnt_q <= {CW{1'b0}};
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            start_q   <= start_d;
        end
    end

    mxu_row_buffer #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM),
        .IDX_W     (CW)
    ) u_buf_a (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept_s),
        .wr_idx  (row_cnt_q),
        .wr_row  (in_row_a),
        .mat     (A)
    );

    mxu_row_buffer #(
        .BIT_WIDTH (BIT_WIDTH),
        .DIM       (DIM),
        .IDX_W     (CW)
    ) u_buf_b (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept_s),
        .wr_idx  (row_cnt_q),
        .wr_row  (in_row_b),
        .mat     (B)
    );

    assign in_ready = in_ready_s;
    assign start    = start_q;
    assign busy     = state_is_busy(state_q);

endmodule

// File: tb/tb_mxu_operand_loader.sv
// Self-checking bench for mxu_operand_loader: scoreboarded row loads, a
// per-cycle control table, reset abort and a behavioural MXU end-to-end check.
module tb_mxu_operand_loader;

    localparam int BW  = 8;
    localparam int DIM = 16;

    typedef logic [DIM-1:0][BW-1:0] row_t;
    typedef struct packed {
        int   idx;
        row_t a;
        row_t b;
    } sb_t;
    typedef struct packed {
        logic iv;
        logic mov;
        logic er;
        logic es;
        logic eb;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid;
    logic in_ready;
    row_t in_row_a;
    row_t in_row_b;
    logic [DIM-1:0][DIM-1:0][BW-1:0] A;
    logic [DIM-1:0][DIM-1:0][BW-1:0] B;
    logic start;
    logic mxu_out_valid;
    logic busy;

    sb_t  sb_q[$];
    row_t exp_a [DIM];
    row_t exp_b [DIM];
    vec_t tbl [38];
    int   model_row;
    int   checks = 0;
    int   passed = 0;

    mxu_operand_loader #(.BIT_WIDTH(BW), .DIM(DIM)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_row_a      (in_row_a),
        .in_row_b      (in_row_b),
        .A             (A),
        .B             (B),
        .start         (start),
        .mxu_out_valid (mxu_out_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic row_t mk_a(input int r, input int salt, input logic ones);
        row_t v;
        for (int c = 0; c < DIM; c++) v[c] = ones ? BW'(1) : BW'(r + c + salt);
        return v;
    endfunction

    function automatic row_t mk_b(input int r, input int salt, input logic ones);
        row_t v;
        for (int c = 0; c < DIM; c++) v[c] = ones ? BW'(1) : BW'((r ^ c) + salt);
        return v;
    endfunction

    function automatic row_t junk();
        row_t v;
        for (int c = 0; c < DIM; c++) v[c] = BW'($urandom);
        return v;
    endfunction

    // Drive one cycle's row data; record it in the scoreboard when it will be accepted.
    task automatic drive_beat(input logic v, input logic will_accept, input int salt, input logic ones);
        sb_t e;
        in_valid = v;
        if (v && will_accept) begin
            in_row_a = mk_a(model_row, salt, ones);
            in_row_b = mk_b(model_row, salt, ones);
            e.idx = model_row;
            e.a = in_row_a;
            e.b = in_row_b;
            sb_q.push_back(e);
            model_row = (model_row + 1) % DIM;
        end else begin
            in_row_a = junk();
            in_row_b = junk();
        end
    endtask

    task automatic cmp_mats(input string tag);
        for (int r = 0; r < DIM; r++) begin
            check($sformatf("%s_A%0d", tag, r), A[r], exp_a[r]);
            check($sformatf("%s_B%0d", tag, r), B[r], exp_b[r]);
        end
    endtask

    task automatic check_load(input string tag);
        sb_t e;
        check({tag, "_sb_cnt"}, sb_q.size(), DIM);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_a[e.idx] = e.a;
            exp_b[e.idx] = e.b;
        end
        cmp_mats(tag);
    endtask

    // Full back-to-back load; start must appear in the cycle after the last accept.
    task automatic run_load(input string tag, input int salt, input logic ones, input logic do_release);
        for (int k = 0; k < DIM; k++) begin
            @(negedge clk);
            if (k == 0 && do_release) reset_n = 1'b1;
            drive_beat(1'b1, 1'b1, salt, ones);
            #1;
            check($sformatf("%s_ready%0d", tag, k), in_ready, 1'b1);
            check($sformatf("%s_nostart%0d", tag, k), start, 1'b0);
        end
        @(negedge clk);
        drive_beat(1'b1, 1'b0, salt, ones);
        #1;
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_ready_start"}, in_ready, 1'b0);
        check_load(tag);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_start_1cyc"}, start, 1'b0);
        check({tag, "_busy_wait"}, busy, 1'b1);
    endtask

    initial begin
        int bad;
        int acc;
        reset_n = 1'b0;
        in_valid = 1'b0;
        mxu_out_valid = 1'b0;
        in_row_a = '0;
        in_row_b = '0;
        model_row = 0;
        for (int r = 0; r < DIM; r++) begin
            exp_a[r] = '0;
            exp_b[r] = '0;
        end

        for (int i = 0; i < 32; i++) tbl[i] = '{iv: 1'(i % 2), mov: 1'b1, er: 1'b1, es: 1'b0, eb: 1'b0};
        tbl[32] = '{iv: 1'b1, mov: 1'b1, er: 1'b0, es: 1'b1, eb: 1'b1};
        for (int i = 33; i < 36; i++) tbl[i] = '{iv: 1'b1, mov: 1'b0, er: 1'b0, es: 1'b0, eb: 1'b1};
        tbl[36] = '{iv: 1'b0, mov: 1'b1, er: 1'b0, es: 1'b0, eb: 1'b1};
        tbl[37] = '{iv: 1'b0, mov: 1'b0, er: 1'b1, es: 1'b0, eb: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("rst_ready", in_ready, 1'b0);
        check("rst_start", start, 1'b0);
        check("rst_busy", busy, 1'b0);
        cmp_mats("rst");
        in_valid = 1'b0;

        // Ramp load straight out of reset: start at cycle 17
        run_load("ramp", 0, 1'b0, 1'b1);

        // WAIT holds operands and refuses input
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            drive_beat(1'b1, 1'b0, 0, 1'b0);
            #1;
            check($sformatf("wait_ready%0d", i), in_ready, 1'b0);
        end
        cmp_mats("wait_hold");
        @(negedge clk);
        in_valid = 1'b0;
        mxu_out_valid = 1'b1;
        #1;
        check("wait_pulse_busy", busy, 1'b1);
        @(negedge clk);
        mxu_out_valid = 1'b0;
        #1;
        check("wait_exit_ready", in_ready, 1'b1);
        check("wait_exit_busy", busy, 1'b0);

        // Toggled in_valid with mxu_out_valid noise in LOAD and START
        model_row = 0;
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            mxu_out_valid = tbl[i].mov;
            drive_beat(tbl[i].iv, tbl[i].er, 7, 1'b0);
            #1;
            check($sformatf("tbl_ready%0d", i), in_ready, tbl[i].er);
            check($sformatf("tbl_start%0d", i), start, tbl[i].es);
            check($sformatf("tbl_busy%0d", i), busy, tbl[i].eb);
        end
        mxu_out_valid = 1'b0;
        check_load("tbl");

        // Reset after 7 accepted rows discards everything
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive_beat(1'b1, 1'b1, 5, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        model_row = 0;
        for (int r = 0; r < DIM; r++) begin
            exp_a[r] = '0;
            exp_b[r] = '0;
        end
        check("abort_ready", in_ready, 1'b0);
        check("abort_start", start, 1'b0);
        cmp_mats("abort");
        @(negedge clk);
        #1;
        check("abort_nostart", start, 1'b0);
        run_load("fresh", 3, 1'b0, 1'b1);
        @(negedge clk);
        mxu_out_valid = 1'b1;
        @(negedge clk);
        mxu_out_valid = 1'b0;
        #1;
        check("fresh_back_ready", in_ready, 1'b1);

        // End-to-end with a behavioural matrix unit: all-ones gives C = DIM
        run_load("e2e", 0, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++) acc += int'(A[i][k]) * int'(B[k][j]);
                if (acc != DIM) bad++;
            end
        end
        check("e2e_C_bad", bad, 0);
        repeat (4) @(negedge clk);
        mxu_out_valid = 1'b1;
        @(negedge clk);
        mxu_out_valid = 1'b0;
        #1;
        check("e2e_ready", in_ready, 1'b1);
        check("e2e_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mxu_operand_loader.md
MXU_OPERAND_LOADER -- requirements
Module: mxu_operand_loader

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, the operand element width.
REQ-002 SHALL have parameter DIM, default 16, the square matrix dimension.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit; the upstream row pair is valid.
REQ-006 SHALL have port in_ready, output, 1 bit; the loader accepts a row pair.
REQ-007 SHALL have port in_row_a, input, [DIM-1:0][BIT_WIDTH-1:0]; one row of A, index = column.
REQ-008 SHALL have port in_row_b, input, [DIM-1:0][BIT_WIDTH-1:0]; one row of B, index = column.
REQ-009 SHALL have port A, output, [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]; the assembled A matrix, [row][col], driven to temporal_mxu.A.
REQ-010 SHALL have port B, output, [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]; the assembled B matrix, driven to temporal_mxu.B.
REQ-011 SHALL have port start, output, 1 bit; a one-cycle launch pulse to temporal_mxu.start.
REQ-012 SHALL have port mxu_out_valid, input, 1 bit; temporal_mxu.out_valid.
REQ-013 SHALL have port busy, output, 1 bit; high in the START and WAIT states.

Function
REQ-014 SHALL implement three states: LOAD, START and WAIT.
REQ-015 LOAD: in_ready=1; a beat is accepted when in_valid && in_ready; accepted rows write A[row_cnt] and B[row_cnt]; row_cnt then increments.
REQ-016 row_cnt SHALL be $clog2(DIM) bits wide; the beat accepted with row_cnt==DIM-1 SHALL move the FSM to START and wrap row_cnt to 0.
REQ-017 START SHALL last exactly one cycle with start=1, then move to WAIT; start SHALL be a registered output and 0 in every other state.
REQ-018 start SHALL assert in the first cycle after the cycle that accepts the final row (latency 1).
REQ-019 WAIT: in_ready=0; on mxu_out_valid=1, return to LOAD on the next edge.
REQ-020 A and B SHALL stay unchanged from the final accept through START and WAIT until the first accept of the next load.
REQ-021 mxu_out_valid SHALL be ignored in LOAD and START.
REQ-022 in_valid SHALL be ignored when in_ready=0; in_row_a and in_row_b SHALL never be sampled outside an accepted beat.
REQ-023 Back-to-back beats SHALL be accepted every cycle: a full load takes DIM cycles when in_valid is held high.
REQ-024 in_valid low mid-load SHALL hold row_cnt and stored rows; the load resumes at the same row.
REQ-025 busy SHALL equal (state != LOAD) combinationally.

Reset
REQ-026 reset_n low SHALL immediately force: state=LOAD, row_cnt=0, start=0, A=0 and B=0 (all elements).
REQ-027 in_ready SHALL be 0 while reset_n is low and 1 in the first cycle after release.
REQ-028 Reset mid-load or mid-WAIT SHALL abort the operation; partial rows are discarded and no start pulse is produced.

Structure
REQ-029 Package mxu_pkg SHALL hold the BIT_WIDTH and DIM defaults and the loader state enum (LOAD, START, WAIT); this module and temporal_mxu SHALL share it.
REQ-030 Sub-module mxu_row_buffer (DIM x DIM x BIT_WIDTH, row write-enable plus row index) SHALL be instantiated twice, once for A and once for B; the FSM and counter SHALL stay in the top module.

Verification
REQ-031 Reset release, in_valid held high, rows with A[r][c]=r+c and B[r][c]=r^c, 16 beats -> start high exactly at cycle 17 for one cycle; A and B match the rows; busy=1.
REQ-032 in_valid toggled 1/0 across 16 rows -> load takes 32 cycles; row_cnt never skips; start fires once; contents are correct.
REQ-033 in WAIT, in_valid=1 for 50 cycles with changing data, mxu_out_valid=0 -> in_ready=0, A/B unchanged; mxu_out_valid pulse -> LOAD next cycle, in_ready=1.
REQ-034 reset_n pulsed low after 7 accepted rows -> A=B=0, row_cnt=0, no start; a fresh 16-row load then completes normally.
REQ-035 mxu_out_valid=1 during LOAD and START -> no state change; one start per load.
REQ-036 end-to-end with temporal_mxu (DIM=16, all ones) -> out_valid rises, every C element equals 16, and the loader returns to LOAD.
